decode_stage: RTL and testbench

- Pipelined RV32I instruction decoder; the producer side of the ALU control interface.
- Accepts fetched instruction/PC beats over a valid/ready handshake.
- Emits registered ALU opcode, operand selects, immediate, register indices and control flags to the execute stage.
- Two-entry skid buffer gives full throughput with a registered in_ready.

---
 rtl/decode_stage_pkg.sv | 79 +++++++
 rtl/decode_stage_comb.sv | 112 +++++++++++
 rtl/decode_stage.sv | 129 ++++++++++++
 tb/tb_decode_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode types: ALU operation enum, major opcodes and the decoded beat record.
// The legality helper is only used when DECODE_ILLEGAL_CHECK_EN is defined.
package rv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_B    = 4'd11
    } alu_op_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        alu_op_t     alu_op;
        logic        a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        branch;
        logic        br_inv;
        logic        jump;
        logic        mem_rd;
        logic        mem_wr;
        logic [2:0]  funct3;
        logic        illegal;
    } decoded_t;

    // Returns 1 for encodings outside the RV32I base set handled by this decoder.
    function automatic logic illegal_encoding(input logic [31:0] instr);
        logic [6:0] f7;
        logic [2:0] f3;
        logic       bad;
        f7  = instr[31:25];
        f3  = instr[14:12];
        bad = (instr[1:0] != 2'b11);
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL: ;
            OPC_JALR:   bad = bad | (f3 != 3'b000);
            OPC_BRANCH: bad = bad | (f3[2:1] == 2'b01);
            OPC_LOAD:   bad = bad | (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
            OPC_STORE:  bad = bad | (f3[2] | (f3[1:0] == 2'b11));
            OPC_OP_IMM: begin
                if (f3 == 3'b001)
                    bad = bad | (f7 != 7'h00);
                else if (f3 == 3'b101)
                    bad = bad | ((f7 != 7'h00) && (f7 != 7'h20));
            end
            OPC_OP: begin
                if (f7 == 7'h20)
                    bad = bad | ((f3 != 3'b000) && (f3 != 3'b101));
                else
                    bad = bad | (f7 != 7'h00);
            end
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// Pure combinational RV32I decoder: instruction word -> decoded_t.
// DECODE_ILLEGAL_CHECK_EN adds illegal-encoding detection that squashes all enables.
module decode_comb
    import rv_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec
);

    function automatic alu_op_t alu_from_funct(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.rd     = instr[11:7];
        dec.funct3 = instr[14:12];
        case (instr[6:0])
            OPC_OP: begin
                dec.alu_op = alu_from_funct(instr[14:12], instr[30], 1'b1);
                dec.rd_we  = 1'b1;
            end
            OPC_OP_IMM: begin
                // I-format immediate already carries shamt in imm[4:0]
                dec.alu_op = alu_from_funct(instr[14:12], instr[30], 1'b0);
                dec.b_sel  = 1'b1;
                dec.imm    = imm_i;
                dec.rd_we  = 1'b1;
            end
            OPC_LUI: begin
                dec.alu_op = ALU_B;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_u;
                dec.rd_we  = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a_sel = 1'b1;
                dec.b_sel = 1'b1;
                dec.imm   = imm_u;
                dec.rd_we = 1'b1;
            end
            OPC_JAL: begin
                dec.a_sel = 1'b1;
                dec.b_sel = 1'b1;
                dec.imm   = imm_j;
                dec.jump  = 1'b1;
                dec.rd_we = 1'b1;
            end
            OPC_JALR: begin
                dec.b_sel = 1'b1;
                dec.imm   = imm_i;
                dec.jump  = 1'b1;
                dec.rd_we = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm    = imm_b;
                dec.branch = 1'b1;
                dec.br_inv = instr[12];
                case (instr[14:13])
                    2'b10:   dec.alu_op = ALU_SLT;
                    2'b11:   dec.alu_op = ALU_SLTU;
                    default: dec.alu_op = ALU_EQ;
                endcase
            end
            OPC_LOAD: begin
                dec.b_sel  = 1'b1;
                dec.imm    = imm_i;
                dec.mem_rd = 1'b1;
                dec.rd_we  = 1'b1;
            end
            OPC_STORE: begin
                dec.b_sel  = 1'b1;
                dec.imm    = imm_s;
                dec.mem_wr = 1'b1;
            end
            default: ;
        endcase
        if (instr[11:7] == 5'd0)
            dec.rd_we = 1'b0;
`ifdef DECODE_ILLEGAL_CHECK_EN
        if (illegal_encoding(instr)) begin
            dec.illegal = 1'b1;
            dec.rd_we   = 1'b0;
            dec.mem_rd  = 1'b0;
            dec.mem_wr  = 1'b0;
            dec.branch  = 1'b0;
            dec.jump    = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined RV32I decode stage with a two-entry skid buffer and registered in_ready.
// Optional DECODE_ILLEGAL_CHECK_EN enables out_illegal reporting (see decode_comb).
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_op,
    output logic            out_a_sel,
    output logic            out_b_sel,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_branch,
    output logic            out_br_inv,
    output logic            out_jump,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    state_t          state_reg, state_next;
    logic            in_ready_reg;
    decoded_t        in_dec;
    decoded_t        main_dec_reg, skid_dec_reg;
    logic [XLEN-1:0] main_pc_reg, skid_pc_reg;
    logic            accept, drain;
    logic            load_main_in, load_main_skid, load_skid_in;

    decode_comb u_decode_comb (
        .instr (in_instr),
        .dec   (in_dec)
    );

    assign accept = in_valid && in_ready_reg;
    assign drain  = (state_reg != ST_EMPTY) && out_ready;

    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: if (accept) begin
                    state_next   = ST_ONE;
                    load_main_in = 1'b1;
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_next   = ST_TWO;
                        load_skid_in = 1'b1;
                    end else if (drain) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: if (drain) begin
                    state_next     = ST_ONE;
                    load_main_skid = 1'b1;
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_EMPTY;
            in_ready_reg <= 1'b1;
            main_dec_reg <= '0;
            skid_dec_reg <= '0;
            main_pc_reg  <= '0;
            skid_pc_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != ST_TWO);
            if (load_main_in) begin
                main_dec_reg <= in_dec;
                main_pc_reg  <= in_pc;
            end else if (load_main_skid) begin
                main_dec_reg <= skid_dec_reg;
                main_pc_reg  <= skid_pc_reg;
            end
            if (load_skid_in) begin
                skid_dec_reg <= in_dec;
                skid_pc_reg  <= in_pc;
            end
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = (state_reg != ST_EMPTY);
    assign out_alu_op  = main_dec_reg.alu_op;
    assign out_a_sel   = main_dec_reg.a_sel;
    assign out_b_sel   = main_dec_reg.b_sel;
    assign out_imm     = XLEN'(signed'(main_dec_reg.imm));
    assign out_rs1     = main_dec_reg.rs1;
    assign out_rs2     = main_dec_reg.rs2;
    assign out_rd      = main_dec_reg.rd;
    assign out_rd_we   = main_dec_reg.rd_we;
    assign out_branch  = main_dec_reg.branch;
    assign out_br_inv  = main_dec_reg.br_inv;
    assign out_jump    = main_dec_reg.jump;
    assign out_mem_rd  = main_dec_reg.mem_rd;
    assign out_mem_wr  = main_dec_reg.mem_wr;
    assign out_funct3  = main_dec_reg.funct3;
    assign out_pc      = main_pc_reg;
    assign out_illegal = main_dec_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, backpressure, flush, async reset.
// Define DECODE_ILLEGAL_CHECK_EN for both bench and RTL to exercise illegal reporting.
module tb_decode_stage;
    import rv_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_alu_op;
    logic            out_a_sel, out_b_sel;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic            out_rd_we, out_branch, out_br_inv, out_jump;
    logic            out_mem_rd, out_mem_wr;
    logic [2:0]      out_funct3;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_alu_op  (out_alu_op),
        .out_a_sel   (out_a_sel),
        .out_b_sel   (out_b_sel),
        .out_imm     (out_imm),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_rd_we   (out_rd_we),
        .out_branch  (out_branch),
        .out_br_inv  (out_br_inv),
        .out_jump    (out_jump),
        .out_mem_rd  (out_mem_rd),
        .out_mem_wr  (out_mem_wr),
        .out_funct3  (out_funct3),
        .out_pc      (out_pc),
        .out_illegal (out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one beat at a falling edge, holds it across one rising edge, then drops valid.
    task automatic send(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        in_instr = instr;
        in_pc    = pc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        $display("tb: beat instr=0x%08h pc=0x%0h accepted", instr, pc);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_imm",       {32'd0, out_imm},   64'd0);
        chk("rst_rd",        {59'd0, out_rd},    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // add x3,x1,x2
        send(32'h002081B3, 32'h100);
        chk("add_valid", {63'd0, out_valid},  64'd1);
        chk("add_op",    {60'd0, out_alu_op}, 64'd0);
        chk("add_rs1",   {59'd0, out_rs1},    64'd1);
        chk("add_rs2",   {59'd0, out_rs2},    64'd2);
        chk("add_rd",    {59'd0, out_rd},     64'd3);
        chk("add_bsel",  {63'd0, out_b_sel},  64'd0);
        chk("add_rdwe",  {63'd0, out_rd_we},  64'd1);
        chk("add_pc",    {32'd0, out_pc},     64'h100);

        send(32'h402081B3, 32'h104);
        chk("sub_op", {60'd0, out_alu_op}, 64'd1);

        // srai x1,x1,3
        send(32'h4030D093, 32'h108);
        chk("srai_op",   {60'd0, out_alu_op},   64'd7);
        chk("srai_bsel", {63'd0, out_b_sel},    64'd1);
        chk("srai_sh",   {59'd0, out_imm[4:0]}, 64'd3);

        send(32'h123450B7, 32'h10C);
        chk("lui_op",  {60'd0, out_alu_op}, 64'd11);
        chk("lui_imm", {32'd0, out_imm},    64'h12345000);
        chk("lui_rd",  {59'd0, out_rd},     64'd1);

        // addi x5,x0,-1
        send(32'hFFF00293, 32'h110);
        chk("addi_imm", {32'd0, out_imm},    64'hFFFFFFFF);
        chk("addi_op",  {60'd0, out_alu_op}, 64'd0);
        chk("addi_rd",  {59'd0, out_rd},     64'd5);

        // bne x1,x2,+8
        send(32'h00209463, 32'h114);
        chk("bne_op",    {60'd0, out_alu_op}, 64'd10);
        chk("bne_br",    {63'd0, out_branch}, 64'd1);
        chk("bne_inv",   {63'd0, out_br_inv}, 64'd1);
        chk("bne_imm",   {32'd0, out_imm},    64'd8);
        chk("bne_rdwe",  {63'd0, out_rd_we},  64'd0);

        // sw x2,4(x1)
        send(32'h0020A223, 32'h118);
        chk("sw_imm",  {32'd0, out_imm},    64'd4);
        chk("sw_wr",   {63'd0, out_mem_wr}, 64'd1);
        chk("sw_rdwe", {63'd0, out_rd_we},  64'd0);
        chk("sw_f3",   {61'd0, out_funct3}, 64'd2);
        @(negedge clk);
        chk("drain_empty", {63'd0, out_valid}, 64'd0);

        // Backpressure: A, B accepted, C refused until a slot frees
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h002081B3; in_pc = 32'h200;
        @(negedge clk);
        chk("bp_a_ready", {63'd0, in_ready}, 64'd1);
        in_instr = 32'hFFF00293; in_pc = 32'h204;
        @(negedge clk);
        in_instr = 32'h123450B7; in_pc = 32'h208;
        chk("bp_two_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_a_rd",      {59'd0, out_rd},   64'd3);
        @(negedge clk);
        chk("bp_stall_ready", {63'd0, in_ready},  64'd0);
        chk("bp_stall_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_stall_rd",    {59'd0, out_rd},    64'd3);
        chk("bp_stall_pc",    {32'd0, out_pc},    64'h200);
        out_ready = 1'b1;
        @(negedge clk);
        $display("tb: beat rd=%0d pc=0x%0h delivered", out_rd, out_pc);
        chk("bp_b_rd",    {59'd0, out_rd},  64'd5);
        chk("bp_b_imm",   {32'd0, out_imm}, 64'hFFFFFFFF);
        chk("bp_b_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        $display("tb: beat rd=%0d pc=0x%0h delivered", out_rd, out_pc);
        chk("bp_c_rd",  {59'd0, out_rd},  64'd1);
        chk("bp_c_imm", {32'd0, out_imm}, 64'h12345000);
        chk("bp_c_pc",  {32'd0, out_pc},  64'h208);
        @(negedge clk);
        chk("bp_done_valid", {63'd0, out_valid}, 64'd0);

        // Flush from TWO, with a competing beat on the input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h002081B3; in_pc = 32'h300;
        @(negedge clk);
        in_instr = 32'h402081B3; in_pc = 32'h304;
        @(negedge clk);
        chk("fl_pre_ready", {63'd0, in_ready}, 64'd0);
        flush    = 1'b1;
        in_instr = 32'h123450B7; in_pc = 32'h308;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        $display("tb: flush applied");
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ready", {63'd0, in_ready},  64'd1);
        @(negedge clk);
        chk("fl_dropped", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset in the middle of a stall
        in_valid = 1'b1;
        in_instr = 32'h002081B3; in_pc = 32'h400;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_pre_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        $display("tb: async reset asserted");
        chk("ar_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_ready", {63'd0, in_ready},  64'd1);
        chk("ar_rd",    {59'd0, out_rd},    64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("ar_post_valid", {63'd0, out_valid}, 64'd0);

        // All-zero word: illegal when checking is enabled, NOP otherwise
        send(32'h00000000, 32'h500);
        chk("zero_valid", {63'd0, out_valid},  64'd1);
        chk("zero_op",    {60'd0, out_alu_op}, 64'd0);
        chk("zero_rdwe",  {63'd0, out_rd_we},  64'd0);
        chk("zero_memrd", {63'd0, out_mem_rd}, 64'd0);
        chk("zero_memwr", {63'd0, out_mem_wr}, 64'd0);
        chk("zero_br",    {63'd0, out_branch}, 64'd0);
        chk("zero_jump",  {63'd0, out_jump},   64'd0);
`ifdef DECODE_ILLEGAL_CHECK_EN
        chk("zero_illegal", {63'd0, out_illegal}, 64'd1);
`else
        chk("zero_illegal", {63'd0, out_illegal}, 64'd0);
`endif
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
